rs_stream_encoder: RTL and testbench

// - Streaming, systematic Reed-Solomon encoder over GF(2^SYM_W).
// - Successor to the fixed 12-bit combinational RS write path. Adds field width, code length,

---
 rtl/rs_pkg.sv | 18 +
 rtl/rs_gf_mul.sv | 37 +++
 rtl/rs_stream_encoder.sv | 156 +++++++++++++++
 tb/tb_rs_stream_encoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and default code parameters for the streaming RS(15,11) encoder.
// Defaults describe GF(16) with x^4+x+1 and a generator with roots alpha^1..alpha^4.
package rs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    localparam int          SYM_W_DEF     = 4;
    localparam logic [4:0]  PRIM_POLY_DEF = 5'b10011;
    localparam int          K_DEF         = 11;
    localparam int          NPAR_DEF      = 4;
    // g[NPAR-1]..g[0]; the leading x^NPAR term is implicit
    localparam logic [15:0] GEN_COEF_DEF  = {4'd13, 4'd12, 4'd8, 4'd7};

endpackage

// File: rtl/rs_gf_mul.sv
// Combinational GF(2^SYM_W) multiplier: carry-less product reduced modulo PRIM_POLY.
module rs_gf_mul #(
    parameter int               SYM_W     = 4,
    parameter logic [SYM_W:0]   PRIM_POLY = 5'b10011
) (
    input  logic [SYM_W-1:0] a,
    input  logic [SYM_W-1:0] b,
    output logic [SYM_W-1:0] y
);

    localparam int PW = 2 * SYM_W - 1;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] poly_ext;
    logic [PW-1:0] prod;

    assign a_ext    = {{(SYM_W - 1){1'b0}}, a};
    assign poly_ext = {{(SYM_W - 2){1'b0}}, PRIM_POLY};

    always_comb begin
        prod = '0;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) begin
                prod = prod ^ (a_ext << i);
            end
        end
        // Fold the high-order terms back in, most significant first
        for (int j = PW - 1; j >= SYM_W; j--) begin
            if (prod[j]) begin
                prod = prod ^ (poly_ext << (j - SYM_W));
            end
        end
    end

    assign y = prod[SYM_W-1:0];

endmodule

// File: rtl/rs_stream_encoder.sv
// Streaming systematic Reed-Solomon encoder: data passes through with zero latency,
// then NPAR parity symbols are shifted out of the division LFSR.
module rs_stream_encoder
    import rs_pkg::*;
#(
    parameter int                       SYM_W     = SYM_W_DEF,
    parameter logic [SYM_W:0]           PRIM_POLY = PRIM_POLY_DEF,
    parameter int                       K         = K_DEF,
    parameter int                       NPAR      = NPAR_DEF,
    parameter logic [NPAR*SYM_W-1:0]    GEN_COEF  = GEN_COEF_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             bypass,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SYM_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [SYM_W-1:0] m_data,
    output logic             m_parity,
    output logic             m_last,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(K + NPAR + 1);
    localparam logic [CNT_W-1:0] CNT_KM1  = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K + NPAR - 1);
    localparam bit               K_ONE    = (K == 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             byp_reg, byp_next;
    logic [SYM_W-1:0] par_reg   [NPAR];
    logic [SYM_W-1:0] par_next  [NPAR];
    logic [SYM_W-1:0] par_cur   [NPAR];
    logic [SYM_W-1:0] prod      [NPAR];
    logic [SYM_W-1:0] lfsr_upd  [NPAR];
    logic [SYM_W-1:0] shift_upd [NPAR];
    logic [SYM_W-1:0] fb;

    // The first symbol of a frame sees a cleared register regardless of leftovers
    assign fb = s_data ^ par_cur[NPAR-1];

    genvar gi;
    generate
        for (gi = 0; gi < NPAR; gi++) begin : g_lfsr
            assign par_cur[gi] = (state_reg == IDLE) ? '0 : par_reg[gi];

            rs_gf_mul #(
                .SYM_W     (SYM_W),
                .PRIM_POLY (PRIM_POLY)
            ) u_mul (
                .a (fb),
                .b (GEN_COEF[gi*SYM_W +: SYM_W]),
                .y (prod[gi])
            );

            if (gi == 0) begin : g_first
                assign lfsr_upd[gi]  = prod[gi];
                assign shift_upd[gi] = '0;
            end else begin : g_rest
                assign lfsr_upd[gi]  = par_cur[gi-1] ^ prod[gi];
                assign shift_upd[gi] = par_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            byp_reg   <= 1'b0;
            for (int i = 0; i < NPAR; i++) begin
                par_reg[i] <= '0;
            end
        end else if (ena) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            byp_reg   <= byp_next;
            for (int i = 0; i < NPAR; i++) begin
                par_reg[i] <= par_next[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        byp_next   = byp_reg;
        par_next   = par_reg;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_parity   = 1'b0;
        m_last     = 1'b0;

        if (ena && rst_n) begin
            case (state_reg)
                IDLE: begin
                    s_ready = m_ready;
                    m_valid = s_valid;
                    m_data  = s_data;
                    m_last  = K_ONE && bypass;
                    if (s_valid && m_ready) begin
                        byp_next = bypass;
                        par_next = lfsr_upd;
                        if (K_ONE) begin
                            state_next = bypass ? IDLE : PARITY;
                            cnt_next   = bypass ? '0 : CNT_W'(1);
                        end else begin
                            state_next = DATA;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    s_ready = m_ready;
                    m_valid = s_valid;
                    m_data  = s_data;
                    m_last  = byp_reg && (cnt_reg == CNT_KM1);
                    if (s_valid && m_ready) begin
                        par_next = lfsr_upd;
                        cnt_next = cnt_reg + 1'b1;
                        if (cnt_reg == CNT_KM1) begin
                            state_next = byp_reg ? IDLE : PARITY;
                            if (byp_reg) begin
                                cnt_next = '0;
                            end
                        end
                    end
                end
                PARITY: begin
                    m_valid  = 1'b1;
                    m_parity = 1'b1;
                    m_data   = par_reg[NPAR-1];
                    m_last   = (cnt_reg == CNT_LAST);
                    if (m_ready) begin
                        par_next = shift_upd;
                        if (cnt_reg == CNT_LAST) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Randomised bench for rs_stream_encoder: a long-division RS(15,11) model and a
// syndrome evaluator check the output stream, handshake stability and gating.
module tb_rs_stream_encoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       bypass;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_data;
    logic       m_parity;
    logic       m_last;
    logic       busy;

    rs_stream_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .bypass   (bypass),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_parity (m_parity),
        .m_last   (m_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int gexp [15];
    int glog [16];
    int gfull [5] = '{1, 13, 12, 8, 7};

    logic [3:0] msg [11];
    logic [4:0] src_q [$];   // {bypass, data}
    logic [5:0] exp_q [$];   // {last, parity, data}
    int         rdy_pat [$];

    int  p_valid = 100;
    int  p_ready = 100;
    bit  sv_hold = 0;
    bit  prev_stall = 0;
    logic [5:0] prev_out = '0;
    int  gap_left = 0;
    bit  gap_arm = 0;
    int  acc_cnt = 0;
    int  frames_done = 0;
    int  drain_cycles = 0;
    int  cw [15];
    int  cw_idx = 0;
    int  last_par [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Systematic encoding as polynomial long division of m(x)*x^4 by g(x)
    task automatic push_frame(input bit byp);
        int c [15];
        for (int i = 0; i < 15; i++) c[i] = (i < 11) ? int'(msg[i]) : 0;
        for (int i = 0; i < 11; i++) begin
            int coef = c[i];
            for (int j = 1; j <= 4; j++) c[i+j] = c[i+j] ^ gmul(coef, gfull[j]);
        end
        for (int i = 0; i < 11; i++) begin
            src_q.push_back({(i == 0) ? byp : 1'($urandom), msg[i]});
            exp_q.push_back({(byp && i == 10), 1'b0, msg[i]});
        end
        if (!byp) begin
            for (int j = 0; j < 4; j++) exp_q.push_back({(j == 3), 1'b1, 4'(c[11+j])});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (gap_left > 0) begin
            ena = 1'b0;
            gap_left--;
        end else begin
            ena = 1'b1;
        end
        if (!sv_hold) sv_hold = (src_q.size() > 0) && ($urandom_range(99) < p_valid);
        s_valid = sv_hold;
        if (src_q.size() > 0) begin
            s_data = src_q[0][3:0];
            bypass = src_q[0][4];
        end else begin
            s_data = 4'($urandom);
            bypass = 1'($urandom);
        end
        m_ready = ($urandom_range(99) < p_ready);
        #1;
        if (rdy_pat.size() > 0 && m_valid && m_parity) m_ready = (rdy_pat.pop_front() != 0);
        #1;
        if (!ena) begin
            check_eq("gated_m_valid", m_valid, 0);
            check_eq("gated_s_ready", s_ready, 0);
            check_eq("gated_busy", busy, 1);
        end
        if (prev_stall && m_valid) check_eq("stall_hold", {m_last, m_parity, m_data}, prev_out);
        prev_stall = m_valid && !m_ready;
        prev_out   = {m_last, m_parity, m_data};
        if (m_valid && m_parity) check_eq("parity_s_ready", s_ready, 0);
        if (s_valid && s_ready) begin
            void'(src_q.pop_front());
            sv_hold = 0;
            acc_cnt++;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", {m_last, m_parity, m_data}, 6'h3f);
            end else begin
                check_eq("out_symbol", {m_last, m_parity, m_data}, exp_q.pop_front());
            end
            if (cw_idx < 15) cw[cw_idx] = int'(m_data);
            cw_idx++;
            if (m_last) begin
                if (m_parity) begin
                    check_eq("codeword_len", cw_idx, 15);
                    for (int j = 1; j <= 4; j++) begin
                        int s = 0;
                        for (int n = 0; n < 15; n++) s = gmul(s, gexp[j]) ^ cw[n];
                        check_eq($sformatf("syndrome%0d", j), s, 0);
                    end
                    for (int j = 0; j < 4; j++) last_par[j] = cw[11+j];
                end
                $display("frame %0d done bypass=%0d symbols=%0d", frames_done, !m_parity, cw_idx);
                frames_done++;
                cw_idx = 0;
            end
        end
        if (gap_arm && m_valid && m_parity) begin
            gap_arm  = 0;
            gap_left = 3;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        drain_cycles = n;
        if (src_q.size() > 0 || exp_q.size() > 0) check_eq("drain_timeout", n, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gexp[0] = 1;
        for (int i = 1; i < 15; i++) begin
            gexp[i] = gexp[i-1] * 2;
            if (gexp[i] >= 16) gexp[i] = gexp[i] ^ 'h13;
        end
        glog[0] = 0;
        for (int i = 0; i < 15; i++) glog[gexp[i]] = i;

        // Reset values, with inputs that would otherwise propagate
        rst_n = 1'b0; ena = 1'b1; bypass = 1'b0;
        s_valid = 1'b1; s_data = 4'h5; m_ready = 1'b1;
        #3;
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_parity", m_parity, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_m_data", m_data, 0);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Two zero frames back to back: 30 transfers in 30 cycles
        foreach (msg[i]) msg[i] = 4'h0;
        push_frame(0);
        push_frame(0);
        drain(200);
        check_eq("b2b_cycles", drain_cycles, 30);
        tick();
        check_eq("busy_after_zero", busy, 0);

        // Unit message, then the same under parity backpressure
        for (int r = 0; r < 2; r++) begin
            foreach (msg[i]) msg[i] = 4'h0;
            msg[10] = 4'h1;
            if (r == 1) rdy_pat = '{1, 0, 0, 1};
            push_frame(0);
            drain(200);
            check_eq("unit_par0", last_par[0], 13);
            check_eq("unit_par1", last_par[1], 12);
            check_eq("unit_par2", last_par[2], 8);
            check_eq("unit_par3", last_par[3], 7);
            last_par = '{0, 0, 0, 0};
        end

        // Bypass frame followed immediately by a normal one
        foreach (msg[i]) msg[i] = 4'(i + 1);
        push_frame(1);
        foreach (msg[i]) msg[i] = 4'($urandom);
        push_frame(0);
        drain(200);

        // Reset after five accepted data symbols
        foreach (msg[i]) msg[i] = 4'($urandom);
        push_frame(0);
        acc_cnt = 0;
        for (int n = 0; n < 50 && acc_cnt < 5; n++) tick();
        check_eq("mid_accepted", acc_cnt, 5);
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = 1'b0;
        src_q.delete();
        exp_q.delete();
        sv_hold = 0; prev_stall = 0; cw_idx = 0;
        #2;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_m_valid", m_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (msg[i]) msg[i] = 4'h0;
        push_frame(0);
        drain(200);
        for (int j = 0; j < 4; j++) check_eq("post_rst_par", last_par[j], 0);

        // Enable gap of three cycles inside the parity phase
        foreach (msg[i]) msg[i] = 4'($urandom);
        gap_arm = 1;
        push_frame(0);
        drain(200);
        check_eq("ena_gap_taken", gap_arm, 0);

        // Random frames with random handshakes, bypass and enable gaps
        p_valid = 70;
        p_ready = 70;
        for (int f = 0; f < 200; f++) begin
            foreach (msg[i]) msg[i] = 4'($urandom);
            gap_arm = ($urandom_range(9) == 0);
            push_frame($urandom_range(7) == 0);
            drain(1000);
            gap_arm = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
